// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: RESET, T0-T7 and HALT states,
// with every datapath strobe decoded from the state, IR[31:27] and BranchOut.
//
// Ports:
//   Clock      system clock (rising edge)
//   Clear      synchronous active-high reset
//   Stop       halt request, only honoured in T0
//   IR         instruction register contents; IR[31:27] is the opcode
//   BranchOut  CON flip-flop result, used in the branch T6 state
//   Run        high in T0-T7
//   remaining outputs are bus drivers, register enables, register-field
//   selects, memory/PC strobes and ALU op strobes for the datapath
module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Stop,
  input  logic [31:0] IR,
  input  logic        BranchOut,
  output logic        Run,
  output logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout,
  output logic        Rout, BAout, Cout, RINout, OutPortOut,
  output logic        PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin,
  output logic        Rin, RAin, CONin, OutPortIn,
  output logic        Gra, Grb, Grc,
  output logic        Read, Write, IncPC,
  output logic        ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL,
  output logic        AND, OR, NEG, NOT
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] w_op;
  logic [3:0] w_last;
  logic       w_alu_reg;
  logic       w_alu_imm;
  logic       w_muldiv;
  logic       w_unused_ir;

  assign w_op        = IR[31:27];
  assign w_unused_ir = ^IR[26:0];
  assign w_alu_reg   = (w_op >= OP_ADD) && (w_op <= OP_SHL);
  assign w_alu_imm   = (w_op >= OP_ADDI) && (w_op <= OP_ORI);
  assign w_muldiv    = (w_op == OP_MUL) || (w_op == OP_DIV);

  // Final state encoding of each instruction; nop and the unused
  // opcodes finish in T2.
  always_comb begin
    w_last = S_T2;
    if (w_op == OP_LD || w_op == OP_ST)
      w_last = S_T7;
    else if (w_muldiv || w_op == OP_BR)
      w_last = S_T6;
    else if (w_op == OP_LDI || w_alu_reg || w_alu_imm)
      w_last = S_T5;
    else if (w_op == OP_NEG || w_op == OP_NOT || w_op == OP_JAL)
      w_last = S_T4;
    else if (w_op >= OP_JR && w_op <= OP_MFHI)
      w_last = S_T3;
    else if (w_op == OP_HALT)
      w_last = S_T3;
  end

  always_ff @(posedge Clock) begin
    if (Clear)
      r_state <= S_RESET;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = Stop ? S_HALT : S_T1;
      S_T1:    w_next = S_T2;
      S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (r_state == S_T3 && w_op == OP_HALT)
          w_next = S_HALT;
        else if (r_state >= w_last)
          w_next = S_T0;
        else
          w_next = state_t'(r_state + 4'd1);
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
  end

  always_comb begin
    Run = (r_state != S_RESET) && (r_state != S_HALT);
    {PCout, Zlowout, Zhighout, MDRout, LOout, HIout} = '0;
    {Rout, BAout, Cout, RINout, OutPortOut} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin} = '0;
    {Rin, RAin, CONin, OutPortIn} = '0;
    {Gra, Grb, Grc, Read, Write, IncPC} = '0;
    {ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL} = '0;
    {AND, OR, NEG, NOT} = '0;
    // Strobes are held off while the datapath is being cleared.
    if (!Clear) begin
      case (r_state)
        S_T0: begin
          if (!Stop) begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
          end
        end
        S_T1: begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
          Read    = 1'b1;
          MDRin   = 1'b1;
        end
        S_T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        S_T3: begin
          unique case (1'b1)
            (w_op == OP_LD || w_op == OP_LDI || w_op == OP_ST): begin
              Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end
            (w_alu_reg || w_alu_imm): begin
              Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end
            w_muldiv: begin
              Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end
            (w_op == OP_NEG || w_op == OP_NOT): begin
              Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
              NEG = (w_op == OP_NEG);
              NOT = (w_op == OP_NOT);
            end
            (w_op == OP_BR): begin
              Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
            end
            (w_op == OP_JR): begin
              Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
            end
            (w_op == OP_JAL): begin
              PCout = 1'b1; RAin = 1'b1;
            end
            (w_op == OP_IN): begin
              RINout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            (w_op == OP_OUT): begin
              Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
            end
            (w_op == OP_MFLO || w_op == OP_MFHI): begin
              LOout = (w_op == OP_MFLO);
              HIout = (w_op == OP_MFHI);
              Gra = 1'b1; Rin = 1'b1;
            end
            default: ;
          endcase
        end
        S_T4: begin
          unique case (1'b1)
            (w_op == OP_LD || w_op == OP_LDI || w_op == OP_ST): begin
              Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
            end
            (w_alu_reg || w_alu_imm): begin
              Grc  = w_alu_reg;
              Rout = w_alu_reg;
              Cout = w_alu_imm;
              Zin  = 1'b1;
              ADD  = (w_op == OP_ADD) || (w_op == OP_ADDI);
              SUB  = (w_op == OP_SUB);
              AND  = (w_op == OP_AND) || (w_op == OP_ANDI);
              OR   = (w_op == OP_OR) || (w_op == OP_ORI);
              ROR  = (w_op == OP_ROR);
              ROL  = (w_op == OP_ROL);
              SHR  = (w_op == OP_SHR);
              SHRA = (w_op == OP_SHRA);
              SHL  = (w_op == OP_SHL);
            end
            w_muldiv: begin
              Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
              MUL = (w_op == OP_MUL);
              DIV = (w_op == OP_DIV);
            end
            (w_op == OP_NEG || w_op == OP_NOT): begin
              Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            (w_op == OP_BR): begin
              PCout = 1'b1; Yin = 1'b1;
            end
            (w_op == OP_JAL): begin
              Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
            end
            default: ;
          endcase
        end
        S_T5: begin
          unique case (1'b1)
            (w_op == OP_LD || w_op == OP_ST): begin
              Zlowout = 1'b1; MARin = 1'b1;
            end
            (w_op == OP_LDI || w_alu_reg || w_alu_imm): begin
              Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            w_muldiv: begin
              Zlowout = 1'b1; LOin = 1'b1;
            end
            (w_op == OP_BR): begin
              Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
            end
            default: ;
          endcase
        end
        S_T6: begin
          unique case (1'b1)
            (w_op == OP_LD): begin
              Read = 1'b1; MDRin = 1'b1;
            end
            (w_op == OP_ST): begin
              Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
            end
            w_muldiv: begin
              Zhighout = 1'b1; HIin = 1'b1;
            end
            (w_op == OP_BR): begin
              Zlowout = BranchOut;
              PCin    = BranchOut;
            end
            default: ;
          endcase
        end
        S_T7: begin
          if (w_op == OP_LD) begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else if (w_op == OP_ST) begin
            MDRout = 1'b1; Write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
